// File: rtl/pipe_if_stage_pkg.sv
// Shared fetch-stage definitions: branch-select codes, reset defaults and FSM states.
package pipe_if_stage_pkg;

  localparam logic [1:0] BRANCH_SEQ  = 2'b00;
  localparam logic [1:0] BRANCH_BR   = 2'b01;
  localparam logic [1:0] BRANCH_JUMP = 2'b10;
  localparam logic [1:0] BRANCH_REG  = 2'b11;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HELD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory request/response handshake.
interface pipe_if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/pipe_if_stage_ifid_reg.sv
// IF/ID pipeline register: reset, bubble insertion, load, otherwise hold.
module pipe_if_stage_ifid_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_p1,
  output logic [31:0] pc4_p1,
  output logic [31:0] inst_p1,
  output logic        vld_p1
);

  // Bubble keeps the PC fields so a jump target can still see the last pc4.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1   <= 32'd0;
      pc4_p1  <= 32'd0;
      inst_p1 <= NOP_INST;
      vld_p1  <= 1'b0;
    end else if (bubble) begin
      inst_p1 <= NOP_INST;
      vld_p1  <= 1'b0;
    end else if (load) begin
      pc_p1   <= pc_in;
      pc4_p1  <= pc_in + 32'd4;
      inst_p1 <= inst_in;
      vld_p1  <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, fetch FSM, next-PC mux and the IF/ID register.
module pipe_if_stage
  import pipe_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [1:0]             branch_sel,
  input  logic [31:0]            branch_target,
  input  logic [31:0]            reg_target,
  pipe_if_stage_if.master        imem,
  output logic [31:0]            ifid_pc,
  output logic [31:0]            ifid_pc4,
  output logic [31:0]            ifid_inst,
  output logic                   ifid_valid,
  output logic [31:0]            fetch_count
);

  fetch_state_t state_p0, state_nxt;
  logic [31:0]  pc_p0, pc_nxt;
  logic [31:0]  rpc_p0, rpc_nxt;
  logic [31:0]  hold_p0, hold_nxt;
  logic         req_p0;
  logic         redirect;
  logic [31:0]  target;
  logic         ifid_ld, ifid_bub, use_hold;

  // A decoded redirect in ID only counts when it is a real instruction and not stalled.
  always_comb begin
    redirect = (branch_sel != BRANCH_SEQ) && !stall && ifid_valid;
    target   = pc_p0;
    case (branch_sel)
      BRANCH_BR:   target = word_align(branch_target);
      BRANCH_JUMP: target = {ifid_pc4[31:28], ifid_inst[25:0], 2'b00};
      BRANCH_REG:  target = word_align(reg_target);
      default:     target = pc_p0;
    endcase
  end

  // Fetch FSM decision: next state, next PC and IF/ID control.
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    rpc_nxt   = rpc_p0;
    hold_nxt  = hold_p0;
    ifid_ld   = 1'b0;
    ifid_bub  = 1'b0;
    use_hold  = 1'b0;
    case (state_p0)
      ST_FETCH, ST_WAIT: begin
        if (redirect && imem.imem_ready) begin
          pc_nxt    = target;
          ifid_bub  = 1'b1;
          state_nxt = ST_FETCH;
        end else if (redirect) begin
          rpc_nxt   = target;
          ifid_bub  = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (imem.imem_ready && !stall) begin
          ifid_ld   = 1'b1;
          pc_nxt    = pc_p0 + 32'd4;
          state_nxt = ST_FETCH;
        end else if (imem.imem_ready) begin
          hold_nxt  = imem.imem_rdata;
          state_nxt = ST_HELD;
        end else begin
          ifid_bub  = !stall;
          state_nxt = ST_WAIT;
        end
      end
      ST_HELD: begin
        if (redirect) begin
          pc_nxt    = target;
          ifid_bub  = 1'b1;
          state_nxt = ST_FETCH;
        end else if (!stall) begin
          ifid_ld   = 1'b1;
          use_hold  = 1'b1;
          pc_nxt    = pc_p0 + 32'd4;
          state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The in-flight access belongs to the squashed path; discard its data.
        ifid_bub = !stall;
        if (imem.imem_ready) begin
          pc_nxt    = rpc_p0;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Fetch state, PC, redirect latch, hold buffer, request and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_FETCH;
      pc_p0       <= RESET_PC;
      rpc_p0      <= RESET_PC;
      hold_p0     <= 32'd0;
      req_p0      <= 1'b1;
      fetch_count <= 32'd0;
    end else begin
      state_p0    <= state_nxt;
      pc_p0       <= pc_nxt;
      rpc_p0      <= rpc_nxt;
      hold_p0     <= hold_nxt;
      req_p0      <= (state_nxt != ST_HELD);
      fetch_count <= fetch_count + {31'd0, ifid_ld};
    end
  end

  // PC stays on the in-flight address during DRAIN, so it is the fetch address in every requesting state.
  assign imem.imem_req  = req_p0;
  assign imem.imem_addr = pc_p0;

  pipe_if_stage_ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_ld),
    .bubble  (ifid_bub),
    .pc_in   (pc_p0),
    .inst_in (use_hold ? hold_p0 : imem.imem_rdata),
    .pc_p1   (ifid_pc),
    .pc4_p1  (ifid_pc4),
    .inst_p1 (ifid_inst),
    .vld_p1  (ifid_valid)
  );

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It owns the PC and drives the instruction-memory handshake. It latches the fetched instruction into IF/ID for the ID-stage decoder, and applies the decoder's 2-bit Branch select (resolved in ID) as a redirect with a one-slot flush. It honours the hazard unit's stall and absorbs slow instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
branch_sel  in  2  from ID decoder: 00 sequential, 01 taken branch, 10 j/jal, 11 register target (jr/eret)
branch_target  in  32  ID-computed PC+4+(sext(imm)<<2)
reg_target  in  32  ID register-file read value for jr/eret
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word aligned)
imem_rdata  in  32  instruction word, valid when imem_ready
imem_ready  in  1  memory has returned data for current request
ifid_pc  out  32  PC of instruction in IF/ID
ifid_pc4  out  32  ifid_pc+4
ifid_inst  out  32  instruction to decoder
ifid_valid  out  1  1 = real instruction, 0 = bubble
fetch_count  out  32  instructions delivered into IF/ID (wraps)

Behaviour:
- Reset (sync, rst=1 at edge): pc=RESET_PC, state=FETCH, ifid_pc=0, ifid_pc4=0, ifid_inst=NOP_INST, ifid_valid=0, fetch_count=0, hold buffer cleared. rst wins over every other input, including mid-WAIT/DRAIN.
- imem_req=1 in FETCH, WAIT, DRAIN; 0 in HELD. imem_addr = pc in FETCH/WAIT, = pc of the in-flight access in DRAIN. It is stable while imem_req=1 and imem_ready=0.
- Redirect is active when branch_sel!=00 and stall=0 and ifid_valid=1. Next PC:
  - 01: branch_target.
  - 10: {ifid_pc4[31:28], ifid_inst[25:0], 2'b00}.
  - 11: reg_target.
- Redirect is ignored while stall=1; the ID instruction is re-evaluated next cycle.
- States: FETCH/WAIT (identical datapath; WAIT only records an outstanding access), HELD, DRAIN.
- FETCH/WAIT, highest priority first:
  - Redirect and imem_ready: pc<=target, IF/ID<=bubble, state FETCH. The returned word is discarded.
  - Redirect and not ready: latch target into redirect_pc, IF/ID<=bubble, state DRAIN.
  - ready and !stall: IF/ID<={pc, pc+4, rdata, 1}, pc<=pc+4, fetch_count++, state FETCH.
  - ready and stall: IF/ID held, rdata into hold buffer, state HELD.
  - not ready and !stall: IF/ID<=bubble, state WAIT.
  - not ready and stall: IF/ID held, state WAIT.
- HELD:
  - Redirect: pc<=target, buffer dropped, IF/ID<=bubble, state FETCH.
  - !stall: IF/ID<={pc, pc+4, buffer, 1}, pc<=pc+4, fetch_count++, state FETCH.
  - stall: hold.
- DRAIN: wait for imem_ready; the response is discarded. Then pc<=redirect_pc, state FETCH. IF/ID<=bubble each DRAIN cycle unless stall. Further redirects are impossible, since IF/ID is a bubble.
- Latency: IF/ID is updated on the edge where imem_ready=1; zero-wait memory gives 1 instruction/cycle. A taken redirect costs exactly 1 bubble with zero-wait memory.
- PC arithmetic is modulo 2^32; pc+4 wraps 0xFFFF_FFFC to 0. Low 2 bits of targets are forced to 0.
- Bubble = ifid_inst=NOP_INST, ifid_valid=0, ifid_pc/pc4 unchanged.

Decomposition:
- Shared pipeline package: BRANCH_SEQ/BR/JUMP/REG (2'b00..11) constants, NOP_INST, RESET_PC default, fetch-state enum.
- One sub-module, ifid_reg: IF/ID register with load/hold/bubble controls and reset.
- FSM and next-PC mux stay in pipe_if_stage.

Test Plan:
- Zero-wait memory, no stall, 4 cycles after reset: ifid_pc = 0, 4, 8, 0xC; ifid_valid=1; fetch_count=4.
- imem_ready low 2 cycles at pc=8: two bubbles (valid=0), imem_addr held at 8. Then ifid_inst=mem[8], pc->0xC.
- ifid_inst=beq at pc=0x10, branch_sel=01, branch_target=0x40: next IF/ID is bubble, then ifid_pc=0x40.
- Stall while word at pc=0x20 returns: state HELD, imem_req=0, IF/ID unchanged 3 cycles. Stall drops: ifid_pc=0x20, inst = held word, no refetch.
- Redirect (branch_sel=11, reg_target=0x100) while imem_ready=0: DRAIN until ready, data discarded. Then imem_addr=0x100, first valid ifid_pc=0x100.
- j with index 0x3FFFFFF at ifid_pc4=0x1000_0004 -> pc=0x1FFF_FFFC. rst asserted during WAIT -> all outputs at reset values next edge.
